// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shift-out on device clocks,
// ACK/NACK and timeout reporting. Open-drain pins are driven through *_oe outputs.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(FILTER_LEN + 1);

    localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_SAT   = '1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          timeout;

    // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_s2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FILT_LAST) begin
            filt_d = clk_s2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + FW'(1);
        end
        fall_d = filt_q & ~filt_d;
    end

    assign timeout  = (tmr_q >= TO_LIMIT);
    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        tmr_d    = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TW'(1);
        sh_d     = sh_q;
        par_d    = par_q;
        bcnt_d   = bcnt_q;
        dat_oe_d = dat_oe_q;
        tx_done  = 1'b0;
        tx_error = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d = S_INHIBIT;
                    sh_d    = tx_data;
                    par_d   = ~^tx_data;
                    bcnt_d  = '0;
                    tmr_d   = '0;
                end
            end
            S_INHIBIT: begin
                if (tmr_q == INH_LAST) begin
                    state_d  = S_REQ;
                    tmr_d    = '0;
                    dat_oe_d = 1'b1;
                end
            end
            S_REQ: begin
                if (timeout) begin
                    tx_error = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (timeout) begin
                    tx_error = 1'b1;
                    state_d  = S_IDLE;
                end else if (fall_q) begin
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q < 4'd8) begin
                        dat_oe_d = ~sh_q[0];
                        sh_d     = {1'b0, sh_q[7:1]};
                    end else if (bcnt_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (timeout) begin
                    tx_error = 1'b1;
                    state_d  = S_IDLE;
                end else if (fall_q) begin
                    if (dat_s2_q) begin
                        tx_error = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (filt_q && dat_s2_q) begin
                    tx_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Data line is only ever pulled while requesting or shifting; every exit releases it.
        if (!((state_d == S_REQ) || (state_d == S_SEND))) dat_oe_d = 1'b0;
        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            fall_q   <= 1'b0;
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            bcnt_q   <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_in;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            fall_q   <= fall_d;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            bcnt_q   <= bcnt_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = dat_oe_q;
endmodule
